// File: rtl/link_pkg.sv
// Shared constants, FIFO entry layout and read-FSM encoding for the link packer.
package link_pkg;
    localparam int TAG_W  = 4;
    localparam int IN_W   = 52;
    localparam int OUT_W  = 64;
    localparam int CNT_W  = 10;
    localparam int BX_W   = 3;

    localparam logic [TAG_W-1:0] TAG_HDR = 4'hA;
    localparam logic [TAG_W-1:0] TAG_DAT = 4'h5;
    localparam logic [TAG_W-1:0] TAG_TRL = 4'hE;

    localparam int HDR_PAD = OUT_W - TAG_W - BX_W;
    localparam int DAT_PAD = OUT_W - TAG_W - IN_W;
    localparam int TRL_PAD = OUT_W - TAG_W - BX_W - CNT_W - 1;

    typedef enum logic {KIND_DATA = 1'b0, KIND_MARKER = 1'b1} kind_t;

    typedef struct packed {
        kind_t             kind;
        logic [IN_W-1:0]   payload;
    } entry_t;

    // Marker payload: summary of the closing event plus the BX of the new one.
    typedef struct packed {
        logic [BX_W-1:0]   close_bx;
        logic [CNT_W-1:0]  cnt;
        logic              ovf;
        logic [BX_W-1:0]   new_bx;
    } marker_t;

    localparam int MARK_W = $bits(marker_t);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_TRL} state_t;
endpackage

// File: rtl/link_packer_if.sv
// Merger-side input and link-side output bundle of the link packer.
interface link_packer_if #(parameter int FIFO_DEPTH = 64);
    import link_pkg::*;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              new_event;
    logic [BX_W-1:0]   BX;
    logic [IN_W-1:0]   in_dat;
    logic              in_valid;
    // out_data transfers on a cycle with out_valid=1 and out_ready=1; while
    // out_valid=1 and out_ready=0, out_valid and out_data stay unchanged.
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic              protocol_err;

    modport slave (
        input  new_event, BX, in_dat, in_valid, out_ready,
        output out_data, out_valid, fifo_level, overflow, protocol_err
    );

    modport master (
        output new_event, BX, in_dat, in_valid, out_ready,
        input  out_data, out_valid, fifo_level, overflow, protocol_err
    );
endinterface

// File: rtl/packer_fifo.sv
// Single-clock FIFO with a registered head stage; o_level counts the head stage too.
module packer_fifo
    import link_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  entry_t         i_wdata,
    input  logic           i_pop,
    output logic           o_rd_valid,
    output entry_t         o_rd_data,
    output logic [LW-1:0]  o_level
);
    entry_t         r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]  r_mcount, r_level;
    logic           r_rd_valid;
    entry_t         r_rd_data;
    logic           w_push, w_load, w_take;

    assign w_push = i_push && (r_level != LW'(DEPTH));
    assign w_take = i_pop && r_rd_valid;
    // Refill the head stage whenever it is empty or being consumed this cycle.
    assign w_load = (r_mcount != '0) && (!r_rd_valid || i_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mcount   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_mcount <= r_mcount + LW'(w_push) - LW'(w_load);
            r_level  <= r_level + LW'(w_push) - LW'(w_take);
            if (w_load)      r_rd_valid <= 1'b1;
            else if (w_take) r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_level    = r_level;
endmodule

// File: rtl/link_packer.sv
// Packs merged readout words into framed link words (header, data, trailer per event).
module link_packer
    import link_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    link_packer_if.slave  bus,
    output state_t        o_dbg_state
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_nev_d1, r_open, r_ovf, r_overflow, r_proto_err;
    logic [BX_W-1:0]   r_bx_pend, r_cur_bx;
    logic [CNT_W-1:0]  r_cnt;
    logic [LW-1:0]     w_level;
    logic              w_fifo_full, w_data_room, w_in_ok, w_bad_in;
    logic              w_push;
    entry_t            w_wdata;
    marker_t           w_new_mark;

    assign w_fifo_full = (w_level == LW'(FIFO_DEPTH));
    assign w_data_room = (w_level <= LW'(FIFO_DEPTH - 2));
    assign w_in_ok     = bus.in_valid && r_open && !r_nev_d1;
    assign w_bad_in    = bus.in_valid && (!r_open || r_nev_d1);
    assign w_new_mark  = '{close_bx: r_cur_bx, cnt: r_cnt, ovf: r_ovf, new_bx: r_bx_pend};

    // Data words stop one slot short of full so a marker always fits.
    always_comb begin
        w_push  = 1'b0;
        w_wdata = '0;
        if (r_nev_d1) begin
            w_push          = !w_fifo_full;
            w_wdata.kind    = KIND_MARKER;
            w_wdata.payload = {{(IN_W-MARK_W){1'b0}}, w_new_mark};
        end else if (w_in_ok && w_data_room) begin
            w_push          = 1'b1;
            w_wdata.kind    = KIND_DATA;
            w_wdata.payload = bus.in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nev_d1    <= 1'b0;
            r_open      <= 1'b0;
            r_bx_pend   <= '0;
            r_cur_bx    <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_nev_d1 <= bus.new_event;
            if (bus.new_event) r_bx_pend <= bus.BX;
            if (r_nev_d1) begin
                r_cur_bx <= r_bx_pend;
                r_open   <= 1'b1;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
                if (w_fifo_full) r_proto_err <= 1'b1;
            end else if (w_in_ok) begin
                if (w_data_room) begin
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_ovf      <= 1'b1;
                    r_overflow <= 1'b1;
                end
            end
            if (w_bad_in) r_proto_err <= 1'b1;
        end
    end

    logic          w_head_valid, w_pop;
    entry_t        w_head;
    marker_t       w_head_mark, r_mark;

    packer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_wdata    (w_wdata),
        .i_pop      (w_pop),
        .o_rd_valid (w_head_valid),
        .o_rd_data  (w_head),
        .o_level    (w_level)
    );

    assign w_head_mark = w_head.payload[MARK_W-1:0];

    state_t            r_state, w_next;
    logic [OUT_W-1:0]  r_out_data, w_out_word;
    logic              r_out_valid, w_out_free, w_load_out;

    assign w_out_free = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_load_out = 1'b0;
        w_out_word = '0;
        case (r_state)
            ST_IDLE: if (w_head_valid) begin
                w_pop = 1'b1;
                if (w_head.kind == KIND_MARKER) w_next = ST_HDR;
            end
            ST_HDR: if (w_out_free) begin
                w_load_out = 1'b1;
                w_out_word = {TAG_HDR, r_mark.new_bx, {HDR_PAD{1'b0}}};
                w_next     = ST_DATA;
            end
            ST_DATA: if (w_head_valid) begin
                if (w_head.kind == KIND_MARKER) begin
                    w_pop  = 1'b1;
                    w_next = ST_TRL;
                end else if (w_out_free) begin
                    w_pop      = 1'b1;
                    w_load_out = 1'b1;
                    w_out_word = {TAG_DAT, {DAT_PAD{1'b0}}, w_head.payload};
                end
            end
            ST_TRL: if (w_out_free) begin
                w_load_out = 1'b1;
                w_out_word = {TAG_TRL, r_mark.close_bx, r_mark.cnt, r_mark.ovf, {TRL_PAD{1'b0}}};
                w_next     = ST_HDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // One marker register serves both the trailer of the closing event and the next header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mark      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop && w_head.kind == KIND_MARKER) r_mark <= w_head_mark;
            if (w_load_out) begin
                r_out_data  <= w_out_word;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.fifo_level   = w_level;
    assign bus.overflow     = r_overflow;
    assign bus.protocol_err = r_proto_err;
    assign o_dbg_state      = r_state;
endmodule
